uart_rx_fifo: RTL

Receive buffer that sits directly downstream of the UART receiver shift register.
- Captures each received byte and its error flag on the receiver's rx_valid.
- Stores entries in a circular FIFO and presents them to the host/bus side via a registered read handshake.
- Reports fill level, threshold, overflow and per-entry error status.

---
 rtl/uart_rx_fifo.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind a UART receiver.
// Each rising edge of rx_valid stores {rx_error, rx_data} into a circular FIFO.
// The host pops entries with rd_en. Read data comes back one cycle later, with a rd_valid pulse.
// Optional idle timeout is enabled by defining UART_RX_FIFO_TIMEOUT_EN.
// That macro adds the baud_divisor input and the rx_timeout output.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_error,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_error,
  output logic                  rd_valid,
  input  logic [ADDR_W:0]       thresh_level,
  input  logic                  overflow_clr,
`ifdef UART_RX_FIFO_TIMEOUT_EN
  input  logic [11:0]           baud_divisor,
  output logic                  rx_timeout,
`endif
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [ADDR_W:0]       fifo_count,
  output logic                  thresh_hit,
  output logic                  overflow
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [DATA_WIDTH:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_count;
  logic                  r_rx_valid_prev;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_error;
  logic                  r_rd_valid;
  logic                  r_overflow;

  logic w_wr_edge;
  logic w_rd_ok;
  logic w_wr_ok;
  logic w_drop;
  logic w_empty;
  logic w_full;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_DEPTH);
  assign w_wr_edge = rx_valid & ~r_rx_valid_prev;
  // A read while empty is ignored, so a same-cycle write never falls through.
  assign w_rd_ok   = rd_en & ~w_empty;
  // When full, a same-cycle read frees the slot that the write then reuses.
  assign w_wr_ok   = w_wr_edge & (~w_full | w_rd_ok);
  assign w_drop    = w_wr_edge & w_full & ~w_rd_ok;

  // rx_valid history for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rx_valid_prev <= 1'b0;
    else       r_rx_valid_prev <= rx_valid;
  end

  // Storage array is kept without reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= {rx_error, rx_data};
  end

  // Pointers and occupancy; the count is kept separately from the pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered read port; the output data holds between pops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_error <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) {r_rd_error, r_rd_data} <= r_mem[r_rd_ptr];
    end
  end

  // Sticky overflow; a new drop wins over a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_overflow <= 1'b0;
    else if (w_drop)       r_overflow <= 1'b1;
    else if (overflow_clr) r_overflow <= 1'b0;
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [19:0] r_idle_cnt;
  logic [19:0] w_idle_limit;
  logic        w_to_en;

  // Four 10-bit character times at the current baud divisor
  assign w_idle_limit = 20'(baud_divisor) * 20'd40;
  assign w_to_en      = (baud_divisor != 12'd0);

  // Idle counter; saturates at the limit and restarts on any FIFO activity
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_idle_cnt <= '0;
    else if (w_wr_edge || w_rd_ok || w_empty)
      r_idle_cnt <= '0;
    else if (w_to_en && (r_idle_cnt < w_idle_limit))
      r_idle_cnt <= r_idle_cnt + 20'd1;
  end

  assign rx_timeout = w_to_en && (r_idle_cnt == w_idle_limit);
`endif

  assign rd_data    = r_rd_data;
  assign rd_error   = r_rd_error;
  assign rd_valid   = r_rd_valid;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;
  assign fifo_empty = w_empty;
  assign fifo_full  = w_full;
  assign thresh_hit = (thresh_level != '0) && (r_count >= thresh_level);

endmodule
